// File: rtl/osc_pkg.sv
// Shared types for the oscillator bank: waveform selector, mixer FSM states
// and the full-scale sample magnitude helper.
package osc_pkg;

  typedef enum logic [1:0] {
    SQUARE   = 2'b00,
    IMPULSE  = 2'b01,
    SAW      = 2'b10,
    TRIANGLE = 2'b11
  } wave_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_OUTPUT = 2'b10
  } mix_state_e;

  // Largest positive value of a signed sample of the given width.
  function automatic int unsigned wave_max(input int unsigned sample_w);
    return (32'd1 << (sample_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/osc_wave_shaper.sv
// Combinational phase-to-sample path: waveform generation from the top phase
// bits followed by unsigned gain with floor-rounded arithmetic scaling.
module osc_wave_shaper
  import osc_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int AMP_W    = 8
) (
  input  logic [SAMPLE_W-1:0]        phase_i,
  input  logic                       wrap_i,
  input  logic [1:0]                 mode_i,
  input  logic [AMP_W-1:0]           amp_i,
  output logic signed [SAMPLE_W-1:0] sample_o
);

  localparam logic signed [SAMPLE_W-1:0] MAX_S  = SAMPLE_W'(wave_max(SAMPLE_W));
  localparam logic signed [SAMPLE_W-1:0] ZERO_S = {SAMPLE_W{1'b0}};

  logic [SAMPLE_W-2:0]               fold_s;
  logic signed [SAMPLE_W-1:0]        tri_s;
  logic signed [SAMPLE_W-1:0]        wave_s;
  logic signed [SAMPLE_W+AMP_W-1:0]  wave_ext_s;
  logic signed [SAMPLE_W+AMP_W-1:0]  amp_ext_s;
  logic signed [SAMPLE_W+AMP_W-1:0]  prod_s;

  // Waveform select and gain stage
  always_comb begin
    fold_s = phase_i[SAMPLE_W-1] ? ~phase_i[SAMPLE_W-2:0] : phase_i[SAMPLE_W-2:0];
    // 2*fold - MAX always lands in -MAX..+MAX, so SAMPLE_W-bit wraparound math is exact
    tri_s  = $signed({fold_s, 1'b0}) - MAX_S;
    case (wave_mode_e'(mode_i))
      SQUARE:   wave_s = phase_i[SAMPLE_W-1] ? -MAX_S : MAX_S;
      IMPULSE:  wave_s = wrap_i ? MAX_S : ZERO_S;
      SAW:      wave_s = $signed({~phase_i[SAMPLE_W-1], phase_i[SAMPLE_W-2:0]});
      TRIANGLE: wave_s = tri_s;
      default:  wave_s = ZERO_S;
    endcase
    wave_ext_s = {{AMP_W{wave_s[SAMPLE_W-1]}}, wave_s};
    amp_ext_s  = $signed({{SAMPLE_W{1'b0}}, amp_i});
    prod_s     = wave_ext_s * amp_ext_s;
    sample_o   = prod_s[AMP_W +: SAMPLE_W];
  end

endmodule

// File: rtl/osc_bank_mixer.sv
// Time-shared oscillator bank: one voice per cycle through a single shaper,
// summed into a wide accumulator. Define MIX_SATURATE_EN to clamp the sum
// instead of scaling it down by the voice count.
module osc_bank_mixer
  import osc_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 24,
  parameter int SAMPLE_W   = 16,
  parameter int AMP_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_tick,
  input  logic [NUM_VOICES-1:0]         voice_en,
  input  logic [2*NUM_VOICES-1:0]       voice_mode,
  input  logic [NUM_VOICES*PHASE_W-1:0] phase_inc,
  input  logic [NUM_VOICES*AMP_W-1:0]   amplitude,
  output logic signed [SAMPLE_W-1:0]    sample_out,
  output logic                          sample_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int SHIFT = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + SHIFT;
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
`ifdef MIX_SATURATE_EN
  localparam logic signed [ACC_W-1:0]    SAT_HI = ACC_W'(wave_max(SAMPLE_W));
  localparam logic signed [ACC_W-1:0]    SAT_LO = ~SAT_HI;
  localparam logic signed [SAMPLE_W-1:0] OUT_HI = SAMPLE_W'(wave_max(SAMPLE_W));
  localparam logic signed [SAMPLE_W-1:0] OUT_LO = ~OUT_HI;
`endif

  mix_state_e                 state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
  logic signed [SAMPLE_W-1:0] sample_out_q;
  logic                       sample_valid_q, busy_q, overrun_q;

  logic                       start_s, accum_s, out_s;
  logic                       cur_en_s, wrap_s;
  logic [1:0]                 cur_mode_s;
  logic [PHASE_W-1:0]         cur_phase_s, cur_inc_s, next_phase_s;
  logic [AMP_W-1:0]           cur_amp_s;
  logic signed [SAMPLE_W-1:0] wave_s, contrib_s, final_s;

  // Current-voice operand selection and phase advance
  always_comb begin
    cur_en_s    = voice_en[idx_q];
    cur_mode_s  = voice_mode[idx_q*2 +: 2];
    cur_inc_s   = phase_inc[idx_q*PHASE_W +: PHASE_W];
    cur_amp_s   = amplitude[idx_q*AMP_W +: AMP_W];
    cur_phase_s = phase_q[idx_q];
    {wrap_s, next_phase_s} = {1'b0, cur_phase_s} + {1'b0, cur_inc_s};
    contrib_s   = cur_en_s ? wave_s : {SAMPLE_W{1'b0}};
  end

  osc_wave_shaper #(
    .SAMPLE_W (SAMPLE_W),
    .AMP_W    (AMP_W)
  ) u_shaper (
    .phase_i  (cur_phase_s[PHASE_W-1 -: SAMPLE_W]),
    .wrap_i   (wrap_s),
    .mode_i   (cur_mode_s),
    .amp_i    (cur_amp_s),
    .sample_o (wave_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) state_d = ST_ACCUM;
        else             state_d = ST_IDLE;
      end
      ST_ACCUM: begin
        if (idx_q == LAST_IDX) state_d = ST_OUTPUT;
        else                   state_d = ST_ACCUM;
      end
      ST_OUTPUT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    start_s = 1'b0;
    accum_s = 1'b0;
    out_s   = 1'b0;
    case (state_q)
      ST_IDLE:   start_s = sample_tick;
      ST_ACCUM:  accum_s = 1'b1;
      ST_OUTPUT: out_s   = 1'b1;
      default: begin
        start_s = 1'b0;
        accum_s = 1'b0;
        out_s   = 1'b0;
      end
    endcase
  end

  // Voice index and accumulator next state, plus final mix stage
  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (start_s) begin
      idx_d = {IDX_W{1'b0}};
      acc_d = {ACC_W{1'b0}};
    end else if (accum_s) begin
      idx_d = idx_q + IDX_ONE;
      acc_d = acc_q + ACC_W'(contrib_s);
    end else begin
      idx_d = idx_q;
      acc_d = acc_q;
    end
`ifdef MIX_SATURATE_EN
    if (acc_q > SAT_HI)      final_s = OUT_HI;
    else if (acc_q < SAT_LO) final_s = OUT_LO;
    else                     final_s = acc_q[SAMPLE_W-1:0];
`else
    final_s = acc_q[ACC_W-1 -: SAMPLE_W];
`endif
  end

  // Datapath, phase and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q          <= {IDX_W{1'b0}};
      acc_q          <= {ACC_W{1'b0}};
      sample_out_q   <= {SAMPLE_W{1'b0}};
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) phase_q[v] <= {PHASE_W{1'b0}};
    end else begin
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      sample_valid_q <= out_s;
      busy_q         <= (state_d != ST_IDLE);
      overrun_q      <= sample_tick && (state_q != ST_IDLE);
      if (out_s) sample_out_q <= final_s;
      // A disabled voice parks at phase 0 so re-enabling restarts cleanly
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (accum_s && (idx_q == IDX_W'(v)))
          phase_q[v] <= cur_en_s ? next_phase_s : {PHASE_W{1'b0}};
      end
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_osc_bank_mixer.sv
// Directed bench for osc_bank_mixer (4 voices); expectations follow the
// MIX_SATURATE_EN setting of the build.
module tb_osc_bank_mixer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_tick = 1'b0;
  logic [3:0]         voice_en = 4'b0;
  logic [7:0]         voice_mode = 8'b0;
  logic [95:0]        phase_inc = 96'b0;
  logic [31:0]        amplitude = 32'b0;
  logic signed [15:0] sample_out;
  logic               sample_valid, busy, overrun;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  osc_bank_mixer #(
    .NUM_VOICES (4),
    .PHASE_W    (24),
    .SAMPLE_W   (16),
    .AMP_W      (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .voice_en     (voice_en),
    .voice_mode   (voice_mode),
    .phase_inc    (phase_inc),
    .amplitude    (amplitude),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Single-voice value after the mix stage: unchanged when saturating, /4 (floor) otherwise.
  function automatic int mix1(input int v);
`ifdef MIX_SATURATE_EN
    return v;
`else
    return v >>> 2;
`endif
  endfunction

  task automatic config_v0(input logic [1:0] mode, input logic [23:0] inc, input logic [7:0] amp);
    voice_en   = 4'b0001;
    voice_mode = {6'b0, mode};
    phase_inc  = {72'b0, inc};
    amplitude  = {24'b0, amp};
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_sample(output logic signed [15:0] val, output int lat);
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    lat = 1;
    while (!sample_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    val = sample_out;
  endtask

  task automatic test_reset;
    logic signed [15:0] v;
    int lat, nval;
    @(negedge clk);
    total++; if (sample_out !== 16'sd0) begin bad++; $display("FAIL reset_out: got %0d expected 0", sample_out); end
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    rst = 1'b0;
    config_v0(2'b00, 24'h400000, 8'd255);
    run_sample(v, lat);
    total++; if (v !== mix1(32639) || lat != 6) begin bad++; $display("FAIL pre_abort_sample: got %0d lat %0d expected %0d lat 6", v, lat, mix1(32639)); end
    // start a second sample and abort it after voice 0 has advanced its phase
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    total++; if (sample_out !== 16'sd0) begin bad++; $display("FAIL abort_out: got %0d expected 0", sample_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
    rst = 1'b0;
    nval = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); nval += int'(sample_valid); end
    total++; if (nval != 0) begin bad++; $display("FAIL abort_no_valid: got %0d pulses expected 0", nval); end
    run_sample(v, lat);
    total++; if (v !== mix1(32639) || lat != 6) begin bad++; $display("FAIL post_reset_phase0: got %0d lat %0d expected %0d lat 6", v, lat, mix1(32639)); end
  endtask

  task automatic test_square;
    int exp_v [4] = '{32639, 32639, -32640, -32640};
    logic signed [15:0] v;
    int lat;
    do_reset();
    config_v0(2'b00, 24'h400000, 8'd255);
    for (int i = 0; i < 4; i++) begin
      run_sample(v, lat);
      total++; if (v !== mix1(exp_v[i]) || lat != 6) begin bad++; $display("FAIL square_%0d: got %0d lat %0d expected %0d lat 6", i, v, lat, mix1(exp_v[i])); end
    end
  endtask

  task automatic test_all_voices;
    logic signed [15:0] v;
    int lat, exp_v;
    do_reset();
    voice_en = 4'hF; voice_mode = 8'h00; phase_inc = 96'b0; amplitude = 32'hFFFF_FFFF;
`ifdef MIX_SATURATE_EN
    exp_v = 32767;
`else
    exp_v = 32639;
`endif
    run_sample(v, lat);
    total++; if (v !== exp_v || lat != 6) begin bad++; $display("FAIL all_voices: got %0d lat %0d expected %0d lat 6", v, lat, exp_v); end
  endtask

  task automatic test_latency;
    int lat;
    do_reset();
    config_v0(2'b00, 24'h000000, 8'd255);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_idle_busy: got %b expected 0", busy); end
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy_rise: got %b expected 1", busy); end
    lat = 1;
    while (!sample_valid && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat != 6) begin bad++; $display("FAIL lat_valid: got %0d cycles expected 6", lat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lat_busy_fall: got %b expected 0", busy); end
    @(negedge clk);
    total++; if (sample_valid !== 1'b0) begin bad++; $display("FAIL lat_valid_pulse: got %b expected 0", sample_valid); end
    for (int i = 0; i < 5; i++) @(negedge clk);
    total++; if (sample_out !== mix1(32639)) begin bad++; $display("FAIL lat_hold: got %0d expected %0d", sample_out, mix1(32639)); end
  endtask

  task automatic test_impulse;
    int exp_v [4] = '{0, 0, 0, 32639};
    logic signed [15:0] v;
    int lat;
    do_reset();
    config_v0(2'b01, 24'h400000, 8'd255);
    for (int i = 0; i < 4; i++) begin
      run_sample(v, lat);
      total++; if (v !== mix1(exp_v[i]) || lat != 6) begin bad++; $display("FAIL impulse_%0d: got %0d lat %0d expected %0d lat 6", i, v, lat, mix1(exp_v[i])); end
    end
  endtask

  task automatic test_saw_triangle;
    int saw_v [4] = '{-32640, -16320, 0, 16320};
    int tri_v [4] = '{-32640, 0, 32639, -1};
    logic signed [15:0] v;
    int lat;
    do_reset();
    config_v0(2'b10, 24'h400000, 8'd255);
    for (int i = 0; i < 4; i++) begin
      run_sample(v, lat);
      total++; if (v !== mix1(saw_v[i]) || lat != 6) begin bad++; $display("FAIL saw_%0d: got %0d lat %0d expected %0d lat 6", i, v, lat, mix1(saw_v[i])); end
    end
    do_reset();
    config_v0(2'b11, 24'h400000, 8'd255);
    for (int i = 0; i < 4; i++) begin
      run_sample(v, lat);
      total++; if (v !== mix1(tri_v[i]) || lat != 6) begin bad++; $display("FAIL triangle_%0d: got %0d lat %0d expected %0d lat 6", i, v, lat, mix1(tri_v[i])); end
    end
  endtask

  task automatic test_disable;
    int exp_v [3] = '{32639, 0, 32639};
    logic signed [15:0] v;
    int lat;
    do_reset();
    config_v0(2'b00, 24'h800000, 8'd255);
    for (int i = 0; i < 3; i++) begin
      voice_en = (i == 1) ? 4'b0000 : 4'b0001;
      run_sample(v, lat);
      total++; if (v !== mix1(exp_v[i]) || lat != 6) begin bad++; $display("FAIL disable_%0d: got %0d lat %0d expected %0d lat 6", i, v, lat, mix1(exp_v[i])); end
    end
  endtask

  task automatic test_overrun;
    logic signed [15:0] v;
    int lat, n_ov, n_val;
    do_reset();
    config_v0(2'b00, 24'h400000, 8'd255);
    n_ov = 0; n_val = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int c = 1; c < 16; c++) begin
      @(negedge clk);
      n_ov  += int'(overrun);
      n_val += int'(sample_valid);
      sample_tick = (c == 2);
    end
    total++; if (n_ov != 1) begin bad++; $display("FAIL overrun_pulses: got %0d expected 1", n_ov); end
    total++; if (n_val != 1) begin bad++; $display("FAIL overrun_valids: got %0d expected 1", n_val); end
    // the ignored tick must not advance the phase: second sample still sees 0x400000
    run_sample(v, lat);
    total++; if (v !== mix1(32639) || lat != 6) begin bad++; $display("FAIL overrun_phase: got %0d lat %0d expected %0d lat 6", v, lat, mix1(32639)); end
    run_sample(v, lat);
    total++; if (v !== mix1(-32640) || lat != 6) begin bad++; $display("FAIL overrun_phase2: got %0d lat %0d expected %0d lat 6", v, lat, mix1(-32640)); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_all_voices();
    test_latency();
    test_impulse();
    test_saw_triangle();
    test_disable();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
